// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - byte-serial memory bus initiator for 1/2/4-byte loads and stores (optional MEM_TIMEOUT_EN)
module mem_bus_master #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              memory_read_en,
    output logic              memory_write_en,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] base_q;
    logic [2:0]        idx_q;
    logic [2:0]        last_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_acc;
    logic [31:0]       acc_merged;
    logic              accept;
    logic              capture;
    logic              timeout;

    // Bus address and write byte follow the base address and the current byte index.
    assign mem_addr  = base_q + ADDR_W'(idx_q);
    assign mem_wdata = wdata_q[{idx_q[1:0], 3'b000} +: 8];

`ifdef MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_cnt;

    // Per-byte wait counter: restarts whenever a byte is acknowledged or RD is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state != RD || capture) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // Read data with the byte currently on the bus merged into its lane.
    always_comb begin
        acc_merged = rdata_acc;
        acc_merged[{idx_q[1:0], 3'b000} +: 8] = mem_rdata;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode; strobes are pure functions of state so reset kills them at once.
    always_comb begin
        state_nxt       = state;
        accept          = 1'b0;
        capture         = 1'b0;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        memory_read_en  = 1'b0;
        memory_write_en = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = req_we ? WR : RD;
                end
            end
            RD: begin
                memory_read_en = 1'b1;
                if (mem_ready) begin
                    capture = 1'b1;
                    if (idx_q == last_q) begin
                        state_nxt = DONE;
                    end
                end else if (timeout) begin
                    state_nxt = DONE;
                end
            end
            WR: begin
                memory_write_en = 1'b1;
                if (idx_q == last_q) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch, byte sequencing, read assembly and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            idx_q      <= '0;
            last_q     <= '0;
            wdata_q    <= '0;
            rdata_acc  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                base_q    <= req_addr;
                idx_q     <= '0;
                wdata_q   <= req_wdata;
                rdata_acc <= '0;
                case (req_size)
                    2'd0:    last_q <= 3'd0;
                    2'd1:    last_q <= 3'd1;
                    default: last_q <= 3'd3;
                endcase
            end
            if (capture) begin
                rdata_acc <= acc_merged;
                idx_q     <= idx_q + 3'd1;
            end
            if (state == WR) begin
                idx_q <= idx_q + 3'd1;
            end
            if (state == RD && state_nxt == DONE) begin
                resp_rdata <= capture ? acc_merged : 32'h0;
                resp_err   <= timeout && !mem_ready;
            end
            if (state == WR && state_nxt == DONE) begin
                resp_rdata <= 32'h0;
                resp_err   <= 1'b0;
            end
        end
    end

endmodule
